snake_dir_queue: RTL
====================

// Module: snake_dir_queue
// PURPOSE
//  Direction-command queue upstream of MIO_BUS. Turns debounced BTN_OK levels into
//  snake direction commands and filters illegal turns. Buffers up to DEPTH commands.
//  The CPU pops one command per game tick through a bus-read strobe and reads a
//  32-bit status/data word through Cpu_data4bus. This keeps fast key taps between
//  ticks from being lost.
// PARAMETERS
//  DEPTH      4     queue entries (power of two, 2..8)
//  INIT_DIR   2'd3  direction after reset/flush (3 = right)
// PORTS
//  clk        in   1   system clock (clk_100mhz domain)
//  RSTN       in   1   asynchronous active-low reset
//  BTN_OK     in   4   debounced button levels: [0]=up [1]=down [2]=left [3]=right
//  rd_en      in   1   1-cycle pop strobe from MIO_BUS address decode
//  flush      in   1   synchronous clear (game over / restart), highest priority
//  dir_word   out  32  {~empty, ovf, 22'b0, count[3:0], 2'b0, head_dir[1:0]}
//  cur_dir    out  2   last popped direction (the snake's current heading)
//  empty      out  1   queue empty
//  full       out  1   queue full
// BEHAVIOUR
//  - Reset (RSTN=0, async): queue empty, count=0, ovf=0, cur_dir=INIT_DIR,
//    button history=0. Outputs: empty=1, full=0, dir_word={1'b0,1'b0,..,4'd0,..,INIT_DIR}.
//  - Edge detect: a press is a 0->1 on BTN_OK[i] against a registered copy. One request per press.
//  - Simultaneous presses in one cycle: lowest index wins; the others are dropped silently.
//  - Reference direction = tail entry if not empty, else cur_dir.
//  - A request is rejected if it equals the reference direction or is its reverse.
//    Reverse pairs: up<->down (0<->1), left<->right (2<->3). A rejected request does not change ovf.
//  - Accepted request: written at tail next edge; count+1; visible in dir_word 1 cycle after the press edge.
//  - Full: a push is dropped and ovf sets (sticky). The exception is a pop in the same cycle:
//    the push is then accepted and count is unchanged.
//  - Pop (rd_en=1, not empty): cur_dir<=head; head advances; count-1.
//    rd_en while empty: no-op, cur_dir holds.
//  - Pop+push same cycle:
//    - Filtering uses the pre-pop tail.
//    - If the queue is empty, the push uses cur_dir as the reference and the pop is a no-op;
//      there is no bypass.
//  - head_dir = head entry when not empty, else cur_dir. Combinational from registers; no read latency.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits,
//    zero-extended to 4 bits in dir_word.
//  - flush=1: same state as reset except button history keeps tracking (held keys do not re-fire).
//    flush overrides push/pop that cycle.
//  - Reset mid-operation: all state cleared immediately, with no partial write.
// STRUCTURE
//  - Shared package snake_pkg: DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_LEFT=2'd2, DIR_RIGHT=2'd3,
//    and function is_reverse(a,b). VGA_Display and FruitReg also use these encodings.
//  - One sub-module: dir_fifo (generic DEPTH x 2-bit FIFO with simultaneous push/pop, tail peek, count).
//    Edge detection, priority and turn filter stay in the top of the block.
// TESTING
//  1 Reset: RSTN=0 then 1 -> empty=1, count=0, cur_dir=3, dir_word=32'h0000_0003.
//  2 Press up, then left, on separate cycles with no pops.
//    -> count=2, head_dir=0; rd_en -> cur_dir=0, head_dir=2; rd_en -> cur_dir=2, empty=1.
//  3 Heading right (empty queue): press left -> rejected, count=0.
//    Press right -> rejected. Press down -> accepted, head_dir=1.
//  4 DEPTH=4: push up,left,down,right (alternating legal turns), then one more legal press.
//    -> full=1, ovf=1 (dir_word[30]=1), count=4. Next push with rd_en the same cycle -> count stays 4.
//  5 BTN_OK=4'b0101 in one edge -> only up queued. Hold 20 cycles -> no extra entries.
//  6 Queue count=3, assert flush together with a press and rd_en
//    -> count=0, ovf=0, cur_dir=3, nothing queued. Pulse RSTN low mid-queue -> same result asynchronously.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : snake_pkg
//  Purpose : Shared snake direction encodings and the reverse-turn helper.
//            VGA_Display and FruitReg use the same encodings.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Opposite directions share bit 1 and differ in bit 0 (up/down, left/right).
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dir_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : dir_fifo
//  Purpose : DEPTH x 2-bit FIFO with simultaneous push/pop, head and tail
//            peek, and an occupancy count.
//  Ports   : clk, rst_n (async active-low), clr (sync clear),
//            push/push_data, pop, head_data, tail_data, count, empty, full
//  Rev     : 1.0  initial release
// ============================================================================
module dir_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [1:0]       push_data,
  input  logic             pop,
  output logic [1:0]       head_data,
  output logic [1:0]       tail_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign tail_ptr  = wr_ptr_q - PTR_W'(1);
  assign head_data = mem_q[rd_ptr_q];
  assign tail_data = mem_q[tail_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still taken when it is paired with a real pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_dir_queue.sv
`default_nettype none
// ============================================================================
//  Module  : snake_dir_queue
//  Purpose : Converts debounced button presses into snake direction commands,
//            rejects same/reverse turns and buffers them until the CPU pops
//            one per game tick.
//  Ports   : clk, RSTN (async active-low), BTN_OK[3:0] (up,down,left,right),
//            rd_en (pop strobe), flush (sync clear),
//            dir_word[31:0] = {~empty, ovf, 22'b0, count[3:0], 2'b0, head_dir},
//            cur_dir[1:0], empty, full
//  Rev     : 1.0  initial release
// ============================================================================
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = 2'd3
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic [3:0]  BTN_OK,
  input  logic        rd_en,
  input  logic        flush,
  output logic [31:0] dir_word,
  output logic [1:0]  cur_dir,
  output logic        empty,
  output logic        full
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [3:0]       btn_q, btn_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       press;
  logic             req_valid;
  logic [1:0]       req_dir;
  logic [1:0]       ref_dir;
  logic             accept;
  logic             push_req;
  logic             pop_ok;

  logic [1:0]       fifo_head;
  logic [1:0]       fifo_tail;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [1:0]       head_dir;
  logic [3:0]       count4;

  always_comb begin
    // History tracks the buttons even during flush so held keys do not re-fire.
    btn_d     = BTN_OK;
    press     = BTN_OK & ~btn_q;
    req_valid = |press;

    // Lowest index wins when several buttons rise together.
    req_dir = DIR_RIGHT;
    if (press[0])      req_dir = DIR_UP;
    else if (press[1]) req_dir = DIR_DOWN;
    else if (press[2]) req_dir = DIR_LEFT;

    // Turns are judged against the last queued command, so a burst of taps
    // forms a legal chain rather than each being compared to the heading.
    ref_dir  = fifo_empty ? cur_dir_q : fifo_tail;
    accept   = req_valid && (req_dir != ref_dir) && !is_reverse(req_dir, ref_dir);
    push_req = accept && !flush;
    pop_ok   = rd_en && !fifo_empty && !flush;

    cur_dir_d = cur_dir_q;
    ovf_d     = ovf_q;
    if (flush) begin
      cur_dir_d = INIT_DIR;
      ovf_d     = 1'b0;
    end else begin
      if (pop_ok) begin
        cur_dir_d = fifo_head;
      end
      if (push_req && fifo_full && !pop_ok) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      btn_q     <= '0;
      cur_dir_q <= INIT_DIR;
      ovf_q     <= 1'b0;
    end else begin
      btn_q     <= btn_d;
      cur_dir_q <= cur_dir_d;
      ovf_q     <= ovf_d;
    end
  end

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (RSTN),
    .clr       (flush),
    .push      (push_req),
    .push_data (req_dir),
    .pop       (pop_ok),
    .head_data (fifo_head),
    .tail_data (fifo_tail),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_dir = fifo_empty ? cur_dir_q : fifo_head;
  assign count4   = 4'(fifo_count);
  assign dir_word = {~fifo_empty, ovf_q, 22'b0, count4, 2'b00, head_dir};
  assign cur_dir  = cur_dir_q;
  assign empty    = fifo_empty;
  assign full     = fifo_full;

endmodule
`default_nettype wire
